// File: rtl/pong_match_ctrl.sv
// Pong match controller: serve countdown, rally, goal pause, scoring and match end.
// Optional build macro PONG_WIN_BY_TWO_EN: a player must also lead by two points to win.
// Saturated scores: at 15, the higher score wins and a 15-15 tie keeps playing.
module pong_match_ctrl #(
   parameter int unsigned WIN_SCORE    = 9,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned PAUSE_FRAMES = 90
) (
   input  logic       px_clk,
   input  logic       reset,
   input  logic       endframe,
   input  logic       start,
   input  logic       goal_ply1,
   input  logic       goal_ply2,
   output logic       play,
   output logic       ball_reset,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       serve_dir,
   output logic [1:0] winner,
   output logic [2:0] state
);

   localparam int unsigned CNT_MAX = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
   localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_RALLY = 3'd2,
      S_GOAL  = 3'd3,
      S_OVER  = 3'd4
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       score1_q, score2_q;
   logic             serve_dir_q;
   logic [1:0]       winner_q;
   logic             play_q, ball_reset_q;
   logic             endframe_q, start_q, goal1_q, goal2_q;

   logic             ft_c, start_rise_c, goal1_c, goal2_c;
   logic             cnt_last_c, p1_wins_c, p2_wins_c;

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s == 4'd15) ? s : s + 4'd1;
   endfunction

   // Rising-edge detection against the previous-cycle input levels
   always_comb begin
      ft_c         = endframe  & ~endframe_q;
      start_rise_c = start     & ~start_q;
      goal1_c      = goal_ply1 & ~goal1_q;
      goal2_c      = goal_ply2 & ~goal2_q;
      cnt_last_c   = (cnt_q <= CNT_W'(1));
   end

`ifdef PONG_WIN_BY_TWO_EN
   logic [4:0] s1_w, s2_w;

   // Win rule: reach WIN_SCORE with a two-point lead, or lead once saturated at 15
   always_comb begin
      s1_w      = {1'b0, score1_q};
      s2_w      = {1'b0, score2_q};
      p1_wins_c = (s1_w >= 5'(WIN_SCORE)) &&
                  ((s1_w >= s2_w + 5'd2) || ((score1_q == 4'd15) && (s1_w > s2_w)));
      p2_wins_c = (s2_w >= 5'(WIN_SCORE)) &&
                  ((s2_w >= s1_w + 5'd2) || ((score2_q == 4'd15) && (s2_w > s1_w)));
   end
`else
   // Win rule: first to reach WIN_SCORE
   always_comb begin
      p1_wins_c = ({1'b0, score1_q} >= 5'(WIN_SCORE));
      p2_wins_c = ({1'b0, score2_q} >= 5'(WIN_SCORE));
   end
`endif

   // Match FSM with registered outputs and frame counter
   always_ff @(posedge px_clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         score1_q     <= 4'd0;
         score2_q     <= 4'd0;
         serve_dir_q  <= 1'b0;
         winner_q     <= 2'b00;
         play_q       <= 1'b0;
         ball_reset_q <= 1'b1;
         endframe_q   <= endframe;
         start_q      <= start;
         goal1_q      <= goal_ply1;
         goal2_q      <= goal_ply2;
      end else begin
         endframe_q <= endframe;
         start_q    <= start;
         goal1_q    <= goal_ply1;
         goal2_q    <= goal_ply2;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  score1_q     <= 4'd0;
                  score2_q     <= 4'd0;
                  winner_q     <= 2'b00;
                  cnt_q        <= CNT_W'(SERVE_FRAMES);
                  state_q      <= S_SERVE;
                  play_q       <= 1'b0;
                  ball_reset_q <= 1'b1;
               end
            end
            S_SERVE: begin
               if (ft_c) begin
                  if (cnt_last_c) begin
                     cnt_q        <= '0;
                     state_q      <= S_RALLY;
                     play_q       <= 1'b1;
                     ball_reset_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
            end
            S_RALLY: begin
               if (goal1_c || goal2_c) begin
                  if (goal1_c && !goal2_c) begin
                     score1_q    <= sat_inc(score1_q);
                     serve_dir_q <= 1'b1;
                  end else if (goal2_c && !goal1_c) begin
                     score2_q    <= sat_inc(score2_q);
                     serve_dir_q <= 1'b0;
                  end
                  cnt_q        <= CNT_W'(PAUSE_FRAMES);
                  state_q      <= S_GOAL;
                  play_q       <= 1'b0;
                  ball_reset_q <= 1'b0;
               end
            end
            S_GOAL: begin
               if (ft_c) begin
                  if (cnt_last_c) begin
                     ball_reset_q <= 1'b1;
                     if (p1_wins_c) begin
                        winner_q <= 2'b01;
                        cnt_q    <= '0;
                        state_q  <= S_OVER;
                     end else if (p2_wins_c) begin
                        winner_q <= 2'b10;
                        cnt_q    <= '0;
                        state_q  <= S_OVER;
                     end else begin
                        cnt_q   <= CNT_W'(SERVE_FRAMES);
                        state_q <= S_SERVE;
                     end
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
            end
            S_OVER: begin
               if (start_rise_c) begin
                  state_q      <= S_IDLE;
                  play_q       <= 1'b0;
                  ball_reset_q <= 1'b1;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               play_q       <= 1'b0;
               ball_reset_q <= 1'b1;
            end
         endcase
      end
   end

   assign state      = state_q;
   assign play       = play_q;
   assign ball_reset = ball_reset_q;
   assign score1     = score1_q;
   assign score2     = score2_q;
   assign serve_dir  = serve_dir_q;
   assign winner     = winner_q;

endmodule
